// File: rtl/cpu_pkg.sv
// Shared definitions for the 4004-style CPU pipeline.
//   - opcode (OPR nibble) constants used by the fetch and execute decoders
//   - microcycle step constants T0..T7
//   - fetch-stage state encoding (first / second instruction word)
package cpu_pkg;

   // OPR nibble values of the two-word instructions
   localparam logic [3:0] OPR_JCN     = 4'h1;
   localparam logic [3:0] OPR_FIM_SRC = 4'h2;
   localparam logic [3:0] OPR_JUN     = 4'h4;
   localparam logic [3:0] OPR_JMS     = 4'h5;
   localparam logic [3:0] OPR_ISZ     = 4'h7;

   // Microcycle steps
   localparam logic [2:0] T0 = 3'd0;
   localparam logic [2:0] T1 = 3'd1;
   localparam logic [2:0] T2 = 3'd2;
   localparam logic [2:0] T3 = 3'd3;
   localparam logic [2:0] T4 = 3'd4;
   localparam logic [2:0] T5 = 3'd5;
   localparam logic [2:0] T6 = 3'd6;
   localparam logic [2:0] T7 = 3'd7;

   typedef enum logic {
      FETCH_FIRST  = 1'b0,
      FETCH_SECOND = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/two_word_decode.sv
// Two-word instruction detector.
// Ports:
//   opr     in  4  first-word upper nibble
//   opa     in  4  first-word lower nibble
//   twoWord out 1  instruction occupies two ROM words
// FIM and SRC share OPR 4'h2; opa[0] distinguishes them (0 = FIM, two words).
module two_word_decode
   import cpu_pkg::*;
(
   input  logic [3:0] opr,
   input  logic [3:0] opa,
   output logic       twoWord
);

   always_comb begin
      twoWord = 1'b0;
      case (opr)
         OPR_JCN,
         OPR_JUN,
         OPR_JMS,
         OPR_ISZ:     twoWord = 1'b1;
         OPR_FIM_SRC: twoWord = ~opa[0];
         default:     twoWord = 1'b0;
      endcase
   end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage of the 4004-style CPU.
// Owns the 12-bit program counter, presents it to ROM as three nibbles in
// T0..T2, captures OPR/OPA (or the second-word operand) in T3/T4, and hands a
// complete instruction to execute during T5..T7. The PC advances at T7 by one
// or loads the execute-requested jump target.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   cycle         microcycle step T0..T7
//   romData       ROM data nibble (sampled T3, T4)
//   jumpValid     PC load request (sampled T7 only)
//   jumpAddr      PC load target
//   romAddr       PC nibble for the current step, 0 outside T0..T2
//   romAddrValid  high in T0..T2
//   pc            program counter
//   opr, opa      first instruction word
//   operand       second instruction word
//   twoWord       latched first word is a two-word opcode
//   wordIndex     0 = fetching first word, 1 = second word
//   instrValid    complete instruction available (T5..T7)
module instruction_fetch
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  cycle,
   input  logic [3:0]  romData,
   input  logic        jumpValid,
   input  logic [11:0] jumpAddr,
   output logic [3:0]  romAddr,
   output logic        romAddrValid,
   output logic [11:0] pc,
   output logic [3:0]  opr,
   output logic [3:0]  opa,
   output logic [7:0]  operand,
   output logic        twoWord,
   output logic        wordIndex,
   output logic        instrValid
);

   fetch_state_t state, state_next;
   logic [11:0]  pc_next;
   logic [11:0]  pc_inc;

   two_word_decode u_decode (
      .opr     (opr),
      .opa     (opa),
      .twoWord (twoWord)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= FETCH_FIRST;
      else     state <= state_next;
   end

   // Next state: the only transitions happen at the microcycle boundary
   always_comb begin
      state_next = state;
      if (cycle == T7) begin
         case (state)
            FETCH_FIRST:  if (twoWord) state_next = FETCH_SECOND;
            FETCH_SECOND: state_next = FETCH_FIRST;
            default:      state_next = FETCH_FIRST;
         endcase
      end
   end

   // PC update; 12-bit arithmetic wraps naturally
   assign pc_inc = pc + 12'd1;

   always_comb begin
      pc_next = pc;
      if (cycle == T7) begin
         // Between the two words of one instruction the jump request is ignored
         if (state == FETCH_FIRST && twoWord) pc_next = pc_inc;
         else if (jumpValid)                  pc_next = jumpAddr;
         else                                 pc_next = pc_inc;
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         pc      <= '0;
         opr     <= '0;
         opa     <= '0;
         operand <= '0;
      end else begin
         pc <= pc_next;
         if (state == FETCH_FIRST) begin
            if (cycle == T3) opr <= romData;
            if (cycle == T4) opa <= romData;
         end else begin
            if (cycle == T3) operand[7:4] <= romData;
            if (cycle == T4) operand[3:0] <= romData;
         end
      end
   end

   // ROM address nibbles, purely cycle-derived selection
   always_comb begin
      romAddr      = 4'h0;
      romAddrValid = 1'b0;
      case (cycle)
         T0: begin romAddr = pc[3:0];  romAddrValid = 1'b1; end
         T1: begin romAddr = pc[7:4];  romAddrValid = 1'b1; end
         T2: begin romAddr = pc[11:8]; romAddrValid = 1'b1; end
         default: begin romAddr = 4'h0; romAddrValid = 1'b0; end
      endcase
   end

   assign wordIndex  = (state == FETCH_SECOND);
   assign instrValid = (cycle >= T5) && (state == FETCH_SECOND || !twoWord);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch. The reference model works one
// microcycle at a time: it reads the ROM word at the model PC, decides from
// the opcode whether a second word follows, and moves the PC at the end.
module tb_instruction_fetch;

   logic        clk;
   logic        rst;
   logic [2:0]  cycle;
   logic [3:0]  romData;
   logic        jumpValid;
   logic [11:0] jumpAddr;
   logic [3:0]  romAddr;
   logic        romAddrValid;
   logic [11:0] pc;
   logic [3:0]  opr;
   logic [3:0]  opa;
   logic [7:0]  operand;
   logic        twoWord;
   logic        wordIndex;
   logic        instrValid;

   instruction_fetch dut (
      .clk          (clk),
      .rst          (rst),
      .cycle        (cycle),
      .romData      (romData),
      .jumpValid    (jumpValid),
      .jumpAddr     (jumpAddr),
      .romAddr      (romAddr),
      .romAddrValid (romAddrValid),
      .pc           (pc),
      .opr          (opr),
      .opa          (opa),
      .operand      (operand),
      .twoWord      (twoWord),
      .wordIndex    (wordIndex),
      .instrValid   (instrValid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int unsigned nvec;
   int unsigned nerr;

   logic [7:0]  rom [4096];

   // Reference model state
   logic [11:0] m_pc;
   logic        m_wi;
   logic [3:0]  m_opr;
   logic [3:0]  m_opa;
   logic [7:0]  m_operand;
   logic        m_two;

   typedef struct {
      logic [3:0] opr;
      logic [3:0] opa;
      logic       two;
   } dec_vec_t;

   dec_vec_t tbl [18];

   // Two-word opcodes are 1,4,5,7 and FIM (2 with even opa)
   function automatic logic ref_two(input logic [3:0] o, input logic [3:0] a);
      logic [15:0] set;
      set = 16'b0000_0000_1011_0010;
      if (o == 4'h2) return (a % 2) == 0;
      return set[o];
   endfunction

   task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = '0; m_wi = 1'b0; m_opr = '0; m_opa = '0; m_operand = '0;
      m_two = ref_two(4'h0, 4'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1; cycle = 3'd5; jumpValid = 1'b1; jumpAddr = 12'hABC; romData = 4'hF;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
   endtask

   // One clock at step c, checking all outputs that are defined at that step
   task automatic do_cycle(input int unsigned c, input logic jv, input logic [11:0] ja,
                           input logic [7:0] word);
      logic [3:0] exp_addr;
      cycle     = c[2:0];
      romData   = (c == 3) ? word[7:4] : (c == 4) ? word[3:0] : 4'($urandom);
      jumpValid = jv;
      jumpAddr  = ja;
      #1;
      exp_addr = (c == 0) ? m_pc[3:0] : (c == 1) ? m_pc[7:4] : (c == 2) ? m_pc[11:8] : 4'h0;
      chk("romAddr",      12'(romAddr),      12'(exp_addr));
      chk("romAddrValid", 12'(romAddrValid), 12'(c < 3));
      chk("pc",           pc,                m_pc);
      chk("wordIndex",    12'(wordIndex),    12'(m_wi));
      chk("instrValid",   12'(instrValid),   12'(c >= 5 && (m_wi || !m_two)));
      if (c >= 5) begin
         chk("opr",     12'(opr),     12'(m_opr));
         chk("opa",     12'(opa),     12'(m_opa));
         chk("operand", 12'(operand), 12'(m_operand));
         chk("twoWord", 12'(twoWord), 12'(m_two));
      end
      @(posedge clk); #1;
   endtask

   // Start of microcycle: model fetches the word at the model PC
   task automatic model_fetch(output logic [7:0] word);
      word = rom[m_pc];
      if (!m_wi) {m_opr, m_opa} = word;
      else       m_operand = word;
      m_two = ref_two(m_opr, m_opa);
   endtask

   // Full microcycle; jvmask[n] drives jumpValid during step n
   task automatic run_mc(input logic [7:0] jvmask, input logic [11:0] ja);
      logic [7:0] word;
      model_fetch(word);
      for (int unsigned c = 0; c < 8; c++) do_cycle(c, jvmask[c], ja, word);
      if (!m_wi && m_two) begin
         m_wi = 1'b1;
         m_pc = m_pc + 12'd1;
      end else begin
         m_pc = jvmask[7] ? ja : m_pc + 12'd1;
         m_wi = 1'b0;
      end
   endtask

   initial begin
      logic [7:0] w;
      nvec = 0; nerr = 0;
      rst = 1'b1; cycle = '0; romData = '0; jumpValid = 1'b0; jumpAddr = '0;
      for (int i = 0; i < 4096; i++) rom[i] = 8'hD5;

      // Reset state
      do_reset();
      cycle = 3'd0; #1;
      chk("rst pc",         pc,               12'h000);
      chk("rst wordIndex",  12'(wordIndex),   12'h0);
      chk("rst opr",        12'(opr),         12'h0);
      chk("rst opa",        12'(opa),         12'h0);
      chk("rst operand",    12'(operand),     12'h0);
      chk("rst romAddrVal", 12'(romAddrValid), 12'h1);
      cycle = 3'd5; #1;
      chk("rst instrValid", 12'(instrValid),  12'h1); // opr 0 = NOP, single word
      cycle = 3'd4; #1;
      chk("rst instrValid T4", 12'(instrValid), 12'h0);

      // Decode table through the full fetch path
      tbl[0]  = '{4'h0, 4'h0, 1'b0};  tbl[1]  = '{4'h1, 4'h3, 1'b1};
      tbl[2]  = '{4'h2, 4'h4, 1'b1};  tbl[3]  = '{4'h2, 4'h5, 1'b0};
      tbl[4]  = '{4'h3, 4'h0, 1'b0};  tbl[5]  = '{4'h4, 4'hF, 1'b1};
      tbl[6]  = '{4'h5, 4'h1, 1'b1};  tbl[7]  = '{4'h6, 4'h2, 1'b0};
      tbl[8]  = '{4'h7, 4'h7, 1'b1};  tbl[9]  = '{4'h8, 4'h0, 1'b0};
      tbl[10] = '{4'h9, 4'h9, 1'b0};  tbl[11] = '{4'hA, 4'h2, 1'b0};
      tbl[12] = '{4'hB, 4'h1, 1'b0};  tbl[13] = '{4'hC, 4'h0, 1'b0};
      tbl[14] = '{4'hD, 4'h5, 1'b0};  tbl[15] = '{4'hE, 4'hE, 1'b0};
      tbl[16] = '{4'hF, 4'h0, 1'b0};  tbl[17] = '{4'h2, 4'hE, 1'b1};
      foreach (tbl[i]) begin
         do_reset();
         rom[0] = {tbl[i].opr, tbl[i].opa};
         run_mc(8'h00, 12'h000);
         chk("tbl twoWord",   12'(twoWord),   12'(tbl[i].two));
         chk("tbl wordIndex", 12'(wordIndex), 12'(tbl[i].two));
         chk("tbl pc",        pc,             12'h001);
      end
      for (int i = 0; i < 4096; i++) rom[i] = 8'hD5;

      // LDM 5 repeated
      do_reset();
      run_mc(8'h00, 12'h000);
      chk("ldm pc1", pc, 12'h001);
      run_mc(8'h00, 12'h000);
      chk("ldm pc2", pc, 12'h002);
      chk("ldm opr", 12'(opr), 12'h00D);
      chk("ldm opa", 12'(opa), 12'h005);

      // JUN 0x123 with the jump taken at the second T7
      do_reset();
      rom[0] = 8'h41; rom[1] = 8'h23;
      run_mc(8'h00, 12'h000);
      chk("jun pc mid", pc, 12'h001);
      chk("jun wi mid", 12'(wordIndex), 12'h1);
      run_mc(8'h80, 12'h123);
      chk("jun pc",      pc, 12'h123);
      chk("jun operand", 12'(operand), 12'h023);
      chk("jun wi",      12'(wordIndex), 12'h0);

      // Jump to FFE, ISZ at FFE/FFF, wrap to 000
      do_reset();
      rom[0] = 8'h4F; rom[1] = 8'hFE; rom[12'hFFE] = 8'h70; rom[12'hFFF] = 8'hAB;
      run_mc(8'h00, 12'h000);
      run_mc(8'h80, 12'hFFE);
      chk("wrap pc FFE", pc, 12'hFFE);
      run_mc(8'h00, 12'h000);
      chk("wrap pc FFF", pc, 12'hFFF);
      chk("wrap wi",     12'(wordIndex), 12'h1);
      run_mc(8'h00, 12'h000);
      chk("wrap pc 000", pc, 12'h000);
      chk("wrap operand", 12'(operand), 12'h0AB);
      rom[0] = 8'hD5; rom[1] = 8'hD5; rom[12'hFFE] = 8'hD5; rom[12'hFFF] = 8'hD5;

      // jumpValid outside T7 and during the first T7 of a two-word fetch
      do_reset();
      rom[1] = 8'h41; rom[2] = 8'h00;
      run_mc(8'b0010_0100, 12'h555);
      chk("jv T2/T5 ignored", pc, 12'h001);
      run_mc(8'h80, 12'h777);
      chk("jv first T7 ignored", pc, 12'h002);
      run_mc(8'h00, 12'h000);
      chk("jv after two-word", pc, 12'h003);
      rom[1] = 8'hD5; rom[2] = 8'hD5;

      // Reset at T4 of the second word of JMS
      do_reset();
      rom[0] = 8'h50; rom[1] = 8'h12;
      run_mc(8'h00, 12'h000);
      model_fetch(w);
      for (int unsigned c = 0; c < 4; c++) do_cycle(c, 1'b0, 12'h000, w);
      cycle = 3'd4; romData = 4'h2; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; cycle = 3'd0; #1;
      model_reset();
      chk("midrst pc",      pc,             12'h000);
      chk("midrst wi",      12'(wordIndex), 12'h0);
      chk("midrst opr",     12'(opr),       12'h0);
      chk("midrst opa",     12'(opa),       12'h0);
      chk("midrst operand", 12'(operand),   12'h0);
      chk("midrst instrValid", 12'(instrValid), 12'h0);
      run_mc(8'h00, 12'h000); // refetches JMS from 0 as a first word
      chk("midrst refetch wi", 12'(wordIndex), 12'h1);

      // Randomized program with random jump requests
      for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
      do_reset();
      for (int n = 0; n < 300; n++) begin
         logic [7:0] mask;
         mask = 8'($urandom);
         if ($urandom_range(3) != 0) mask[7] = 1'b0;
         run_mc(mask, 12'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
